// File: rtl/opb_s2p_pkg.sv
// Shared types and register-map helpers for the simulink-to-PPC status bank.
package opb_s2p_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } hs_state_e;

    localparam int FREEZE_BIT   = 0;
    localparam int CLR_BIT      = 1;
    localparam int STAT_FRZ_BIT = 16;
    localparam int UPD_CNT_W    = 16;

    // Byte offsets of the two housekeeping registers that follow the N data words.
    function automatic logic [7:0] status_off(input int n);
        return 8'(4 * n);
    endfunction

    function automatic logic [7:0] ctrl_off(input int n);
        return 8'(4 * n + 4);
    endfunction

endpackage

// File: rtl/opb_slave_handshake.sv
// OPB address decode and the single-beat acknowledge sequencer.
//  state | meaning
//  IDLE  | waiting for a selected in-window address
//  ACK   | xferAck high for one cycle, write side-effects commit
//  HOLD  | turnaround cycle, no ack even if select stays high
module opb_slave_handshake
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h010B2300,
    parameter logic [31:0] HIGH_ADDR = 32'h010B23FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] abus,
    input  logic        select,
    input  logic        rnw,
    output logic        ack,
    output logic        rnw_q,
    output logic [5:0]  word_idx_q
);

    hs_state_e   state;
    hs_state_e   state_nxt;
    logic        hit;
    logic [31:0] off;
    logic        unused_off;

    assign hit        = select && (abus >= BASE_ADDR) && (abus <= HIGH_ADDR);
    assign off        = abus - BASE_ADDR;
    assign unused_off = ^{off[31:8], off[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transfer attributes are latched once, when the request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnw_q      <= 1'b0;
            word_idx_q <= '0;
        end else if (state == IDLE && hit) begin
            rnw_q      <= rnw;
            word_idx_q <= off[7:2];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack = (state == ACK);
    end

endmodule

// File: rtl/opb_register_simulink2ppc_bank.sv
// OPB read-back bank for fabric status words: live shadow, coherent snapshot,
// update counter and a freeze control that stops capture.
module opb_register_simulink2ppc_bank
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B2300,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B23FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_WORDS  = 4
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [C_NUM_WORDS*32-1:0]   user_data_in,
    input  logic                        user_valid,
    output logic                        user_frozen
);

    logic                 ack;
    logic                 rnw_q;
    logic [5:0]           word_idx_q;
    logic [7:0]           off_q;
    logic [31:0]          shadow [C_NUM_WORDS];
    logic [31:0]          snap   [C_NUM_WORDS];
    logic [UPD_CNT_W-1:0] upd_cnt;
    logic                 freeze;
    logic                 cap;
    logic                 rd0;
    logic                 ctrl_wr;
    logic                 clr_cnt;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 unused_ok;

    opb_slave_handshake #(
        .BASE_ADDR (C_BASEADDR),
        .HIGH_ADDR (C_HIGHADDR)
    ) u_handshake (
        .clk        (OPB_Clk),
        .rst        (OPB_Rst),
        .abus       (OPB_ABus),
        .select     (OPB_select),
        .rnw        (OPB_RNW),
        .ack        (ack),
        .rnw_q      (rnw_q),
        .word_idx_q (word_idx_q)
    );

    // OPB bit 0 is the MSB, so a whole-vector copy preserves the numeric value.
    assign wdata     = OPB_DBus;
    assign off_q     = {word_idx_q, 2'b00};
    assign cap       = user_valid && !freeze;
    assign rd0       = ack && rnw_q && (word_idx_q == 6'd0);
    assign ctrl_wr   = ack && !rnw_q && (off_q == ctrl_off(C_NUM_WORDS))
                       && OPB_BE[C_OPB_DWIDTH/8-1];
    assign clr_cnt   = ctrl_wr && wdata[CLR_BIT];
    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:C_OPB_DWIDTH/8-2], wdata[31:2]};

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int k = 0; k < C_NUM_WORDS; k++) begin
                shadow[k] <= '0;
                snap[k]   <= '0;
            end
            upd_cnt     <= '0;
            freeze      <= 1'b0;
            user_frozen <= 1'b0;
        end else begin
            for (int k = 0; k < C_NUM_WORDS; k++) begin
                if (cap) shadow[k] <= user_data_in[32*k +: 32];
                if (rd0) snap[k]   <= shadow[k];
            end
            // A word-0 read restarts the count; a capture in that same cycle counts as one.
            if (rd0) begin
                upd_cnt <= cap ? UPD_CNT_W'(1) : '0;
            end else if (clr_cnt) begin
                upd_cnt <= '0;
            end else if (cap && upd_cnt != '1) begin
                upd_cnt <= upd_cnt + 1'b1;
            end
            if (ctrl_wr) freeze <= wdata[FREEZE_BIT];
            user_frozen <= freeze;
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < C_NUM_WORDS; k++) begin
            if (word_idx_q == 6'(k)) rdata = (k == 0) ? shadow[0] : snap[k];
        end
        if (off_q == status_off(C_NUM_WORDS)) begin
            rdata[UPD_CNT_W-1:0] = upd_cnt;
            rdata[STAT_FRZ_BIT]  = freeze;
        end
        if (off_q == ctrl_off(C_NUM_WORDS)) rdata[FREEZE_BIT] = freeze;
    end

    assign Sl_DBus    = (ack && rnw_q) ? rdata : '0;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_bank.sv
// Scoreboard bench: driver pushes expected acks from a register-level model,
// a negedge monitor pops and compares whenever the slave acknowledges.
module tb_opb_register_simulink2ppc_bank;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h010B2300;

    logic             OPB_Clk;
    logic             OPB_Rst;
    logic [0:31]      OPB_ABus;
    logic [0:3]       OPB_BE;
    logic [0:31]      OPB_DBus;
    logic             OPB_RNW;
    logic             OPB_select;
    logic             OPB_seqAddr;
    logic [0:31]      Sl_DBus;
    logic             Sl_xferAck;
    logic             Sl_errAck;
    logic             Sl_retry;
    logic             Sl_toutSup;
    logic [N*32-1:0]  user_data_in;
    logic             user_valid;
    logic             user_frozen;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_acks  = 0;
    int          cyc     = 0;
    bit          started = 0;
    logic [31:0] uv_words [N];

    logic [31:0] m_shadow [N];
    logic [31:0] m_snap   [N];
    int          m_cnt;
    bit          m_freeze;
    bit          m_frozen;

    bit          ack_now;
    bit          x_rnw;
    int          x_idx;
    logic [31:0] x_data;
    logic [3:0]  x_be;

    opb_register_simulink2ppc_bank dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .user_frozen  (user_frozen)
    );

    initial OPB_Clk = 1'b0;
    always #5 OPB_Clk = ~OPB_Clk;
    always @(posedge OPB_Clk) cyc <= cyc + 1;

    always_comb begin
        user_data_in = '0;
        for (int k = 0; k < N; k++) user_data_in[32*k +: 32] = uv_words[k];
    end

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endfunction

    // Register-level view of what a read at word index idx returns right now.
    function automatic logic [31:0] model_read(input int idx);
        if (idx == 0)          return m_shadow[0];
        else if (idx < N)      return m_snap[idx];
        else if (idx == N)     return (m_freeze ? 32'h0001_0000 : 32'h0) | 32'(m_cnt);
        else if (idx == N + 1) return m_freeze ? 32'h1 : 32'h0;
        else                   return 32'h0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = '0;
            m_snap[k]   = '0;
        end
        m_cnt    = 0;
        m_freeze = 0;
        m_frozen = 0;
    endfunction

    function automatic void model_edge();
        bit cap, rd0, cw;
        cap = user_valid && !m_freeze;
        rd0 = ack_now && x_rnw && (x_idx == 0);
        cw  = ack_now && !x_rnw && (x_idx == N + 1) && x_be[0];
        m_frozen = m_freeze;
        if (rd0) for (int k = 0; k < N; k++) m_snap[k] = m_shadow[k];
        if (rd0)                       m_cnt = cap ? 1 : 0;
        else if (cw && x_data[1])      m_cnt = 0;
        else if (cap && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (cap) for (int k = 0; k < N; k++) m_shadow[k] = uv_words[k];
        if (cw) m_freeze = x_data[0];
    endfunction

    task automatic step();
        @(posedge OPB_Clk);
        #1;
        if (OPB_Rst) model_reset();
        else model_edge();
        ack_now = 0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < N; k++) uv_words[k] = $urandom;
    endtask

    task automatic pulse();
        user_valid = 1'b1;
        step();
        user_valid = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] data,
                        input logic [3:0] be, input bit uv, input string name);
        exp_t e;
        int   idx;
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_DBus   = rnw ? 32'h0 : data;
        OPB_BE     = be;
        OPB_select = 1'b1;
        step();
        idx    = int'((addr - BASE) >> 2);
        e.cyc  = cyc;
        e.data = rnw ? model_read(idx) : 32'h0;
        e.name = name;
        exp_q.push_back(e);
        if (uv) begin
            rand_words();
            user_valid = 1'b1;
        end
        ack_now = 1; x_rnw = rnw; x_idx = idx; x_data = data; x_be = be;
        step();
        OPB_select = 1'b0;
        user_valid = 1'b0;
        step();
        check("user_frozen", {31'b0, user_frozen}, {31'b0, m_frozen});
    endtask

    always @(negedge OPB_Clk) begin
        if (started) begin
            if (Sl_xferAck === 1'b1) begin
                n_acks++;
                check("tied_outputs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {31'b0, Sl_xferAck}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                    check(e.name, Sl_DBus, e.data);
                end
            end else if (OPB_select) begin
                check("idle_dbus", Sl_DBus, 32'h0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, c0, op, idx;
        exp_t e;
        OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
        OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_valid = 1'b0; ack_now = 0;
        for (int k = 0; k < N; k++) uv_words[k] = '0;
        model_reset();
        step(); step();
        OPB_Rst = 1'b0;
        started = 1;

        xfer(32'h010B2310, 1, 0, 4'hF, 0, "reset_status");

        for (int k = 0; k < N; k++) uv_words[k] = 32'h11111111 * (k + 1);
        pulse();
        xfer(32'h010B2300, 1, 0, 4'hF, 0, "coh_data0");
        for (int k = 0; k < N; k++) uv_words[k] = 32'hAAAAAAA0 + k;
        pulse();
        xfer(32'h010B2308, 1, 0, 4'hF, 0, "coh_data2");
        xfer(32'h010B2310, 1, 0, 4'hF, 0, "coh_status");

        xfer(32'h010B2314, 0, 32'h1, 4'b1111, 0, "wr_freeze");
        for (int k = 0; k < N; k++) uv_words[k] = 32'h55555555;
        pulse();
        xfer(32'h010B2300, 1, 0, 4'hF, 0, "frozen_data0");
        xfer(32'h010B2310, 1, 0, 4'hF, 0, "frozen_status");
        xfer(32'h010B2314, 0, 32'h0, 4'b1111, 0, "wr_unfreeze");

        xfer(32'h010B2314, 0, 32'h1, 4'b1110, 0, "wr_be_guard");
        xfer(32'h010B2314, 1, 0, 4'hF, 0, "be_guard_ctrl");

        OPB_ABus = 32'h010B2400; OPB_RNW = 1'b1; OPB_select = 1'b1;
        a0 = n_acks;
        repeat (8) step();
        OPB_select = 1'b0;
        check("oow_ack_count", 32'(n_acks), 32'(a0));

        OPB_ABus = 32'h010B2310; OPB_RNW = 1'b1; OPB_select = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            e.cyc = c0 + 1 + 3 * i; e.data = model_read(N); e.name = "cont_status";
            exp_q.push_back(e);
        end
        repeat (8) step();
        OPB_select = 1'b0;
        step();

        xfer(32'h010B2300, 1, 0, 4'hF, 1, "uv_with_data0");
        xfer(32'h010B2310, 1, 0, 4'hF, 0, "uv_with_data0_status");
        pulse();
        xfer(32'h010B2314, 0, 32'h2, 4'b1111, 1, "clr_with_uv");
        xfer(32'h010B2310, 1, 0, 4'hF, 0, "clr_with_uv_status");
        xfer(32'h010B2314, 0, 32'h1, 4'b1111, 1, "freeze_with_uv");
        xfer(32'h010B2300, 1, 0, 4'hF, 0, "freeze_with_uv_data0");
        xfer(32'h010B2314, 0, 32'h0, 4'b1111, 0, "wr_unfreeze2");
        xfer(32'h010B23FF, 1, 0, 4'hF, 0, "top_of_window");

        user_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            rand_words();
            step();
        end
        user_valid = 1'b0;
        xfer(32'h010B2310, 1, 0, 4'hF, 0, "sat_status");

        OPB_ABus = 32'h010B2300; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
        step();
        e.cyc = cyc; e.data = model_read(0); e.name = "rst_mid_ack";
        exp_q.push_back(e);
        OPB_Rst = 1'b1; OPB_select = 1'b0;
        step();
        check("ack_after_rst", {31'b0, Sl_xferAck}, 32'h0);
        step();
        OPB_Rst = 1'b0;
        step();
        xfer(32'h010B2300, 1, 0, 4'hF, 0, "post_rst_data0");

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin rand_words(); pulse(); end
                1: begin
                    idx = $urandom_range(0, N + 3);
                    xfer(BASE + 32'(idx * 4 + $urandom_range(0, 3)), 1, 0, 4'hF,
                         ($urandom_range(0, 3) == 0), "rand_read");
                end
                2: xfer(BASE + 32'(4 * (N + 1)), 0, 32'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1), "rand_ctrl_wr");
                default: begin
                    idx = $urandom_range(0, N);
                    xfer(BASE + 32'(idx * 4), 0, $urandom, 4'hF, 0, "rand_ro_wr");
                end
            endcase
            repeat ($urandom_range(0, 2)) step();
        end
        xfer(32'h010B2310, 1, 0, 4'hF, 0, "final_status");

        repeat (3) step();
        check("pending_acks", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
